// File: rtl/sreg_tx_pkg.sv
// Shared definitions for the CPLD address shift-register link: default
// address width, FSM state encodings and the serial pin bundle.
package sreg_tx_pkg;

  localparam int DWIDTH_DEF = 21;
  localparam int CLKDIV_DEF = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SH_LO  = 3'd1;
  localparam logic [2:0] ST_SH_HI  = 3'd2;
  localparam logic [2:0] ST_INC_LO = 3'd3;
  localparam logic [2:0] ST_INC_HI = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Control pins driven towards the CPLD (data pin comes from the shadow).
  typedef struct packed {
    logic sclk;
    logic en_n;
    logic counter_n;
  } sreg_pins_t;

  localparam sreg_pins_t PINS_IDLE = '{sclk: 1'b0, en_n: 1'b1, counter_n: 1'b1};

endpackage

// File: rtl/sreg_tx_tick_gen.sv
// Half-period timer: counts CLKDIV clk cycles and emits a one-cycle tick on
// the last one. Restart holds the count at zero; the count also wraps to
// zero by itself after each tick so consecutive states get equal length.
module sreg_tx_tick_gen #(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int TW = $clog2(CLKDIV + 1);
  localparam logic [TW-1:0] TERM = TW'(CLKDIV - 1);

  logic [TW-1:0] cnt_r;

  // Half-period counter, cleared on restart and after every tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {TW{1'b0}};
    end else if (restart || (cnt_r == TERM)) begin
      cnt_r <= {TW{1'b0}};
    end else begin
      cnt_r <= cnt_r + TW'(1);
    end
  end

  assign tick = (cnt_r == TERM);

endmodule

// File: rtl/sreg_tx.sv
// Host-side serializer for the CPLD address shift register. Shifts a latched
// address out MSB first (sreg_en_n low) or issues one increment strobe
// (sreg_en_n high, sreg_counter_n low). All pin outputs come from registers.
module sreg_tx
  import sreg_tx_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DWIDTH-1:0] addr,
  input  logic              incr,
  output logic              busy,
  output logic              done,
  output logic              sreg_clk,
  output logic              sreg_in,
  output logic              sreg_en_n,
  output logic              sreg_counter_n
);

  localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);

  logic [2:0]        state_r;
  logic [DWIDTH-1:0] shadow_r;
  logic [BW-1:0]     bitcnt_r;
  sreg_pins_t        pins_r;
  logic              busy_r;
  logic              done_r;
  logic              tick_s;
  logic              restart_s;

  // The timer only runs while a transfer is in progress.
  assign restart_s = (state_r == ST_IDLE);

  sreg_tx_tick_gen #(
    .CLKDIV (CLKDIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Transfer FSM with shadow, bit counter and registered pin values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      shadow_r <= {DWIDTH{1'b0}};
      bitcnt_r <= {BW{1'b0}};
      pins_r   <= PINS_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // load has priority; a simultaneous incr is dropped, not queued
          if (load) begin
            shadow_r         <= addr;
            bitcnt_r         <= BIT_LAST;
            pins_r.sclk      <= 1'b0;
            pins_r.en_n      <= 1'b0;
            pins_r.counter_n <= 1'b1;
            busy_r           <= 1'b1;
            state_r          <= ST_SH_LO;
          end else if (incr) begin
            pins_r.sclk      <= 1'b0;
            pins_r.en_n      <= 1'b1;
            pins_r.counter_n <= 1'b0;
            busy_r           <= 1'b1;
            state_r          <= ST_INC_LO;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SH_LO: begin
          if (tick_s) begin
            pins_r.sclk <= 1'b1;
            state_r     <= ST_SH_HI;
          end else begin
            state_r <= ST_SH_LO;
          end
        end
        ST_SH_HI: begin
          if (tick_s) begin
            pins_r.sclk <= 1'b0;
            // bitcnt is tested before decrementing, so it never wraps
            if (bitcnt_r == {BW{1'b0}}) begin
              state_r <= ST_FINISH;
            end else begin
              shadow_r <= {shadow_r[DWIDTH-2:0], 1'b0};
              bitcnt_r <= bitcnt_r - BW'(1);
              state_r  <= ST_SH_LO;
            end
          end else begin
            state_r <= ST_SH_HI;
          end
        end
        ST_INC_LO: begin
          if (tick_s) begin
            pins_r.sclk <= 1'b1;
            state_r     <= ST_INC_HI;
          end else begin
            state_r <= ST_INC_LO;
          end
        end
        ST_INC_HI: begin
          if (tick_s) begin
            pins_r.sclk <= 1'b0;
            state_r     <= ST_FINISH;
          end else begin
            state_r <= ST_INC_HI;
          end
        end
        ST_FINISH: begin
          // enables stay active one half-period after the last fall (hold)
          if (tick_s) begin
            pins_r   <= PINS_IDLE;
            shadow_r <= {DWIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_FINISH;
          end
        end
        default: begin
          pins_r   <= PINS_IDLE;
          shadow_r <= {DWIDTH{1'b0}};
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign sreg_clk       = pins_r.sclk;
  assign sreg_in        = shadow_r[DWIDTH-1];
  assign sreg_en_n      = pins_r.en_n;
  assign sreg_counter_n = pins_r.counter_n;

endmodule

// File: tb/tb_sreg_tx.sv
// Scoreboard bench for sreg_tx: one instance with CLKDIV=2 and one with
// CLKDIV=1, each feeding a behavioural CPLD receiver model.
module tb_sreg_tx;

  localparam int DW = 21;

  typedef struct {
    int           lat;
    logic [DW-1:0] rx;
    int           rises;
    int           start;
  } exp_t;

  exp_t q[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_s = 1'b1;
  logic          load_s  = 1'b0;
  logic          incr_s  = 1'b0;
  logic          sel     = 1'b0;
  logic [DW-1:0] addr_s  = '0;
  logic [DW-1:0] rx_exp  = '0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic busy2, done2, sclk2, sin2, en2, cnt2;
  logic busy1, done1, sclk1, sin1, en1, cnt1;

  sreg_tx #(.DWIDTH(DW), .CLKDIV(2)) u_dut2 (
    .clk(clk), .reset(reset_s), .load(load_s & ~sel), .addr(addr_s),
    .incr(incr_s & ~sel), .busy(busy2), .done(done2), .sreg_clk(sclk2),
    .sreg_in(sin2), .sreg_en_n(en2), .sreg_counter_n(cnt2)
  );

  sreg_tx #(.DWIDTH(DW), .CLKDIV(1)) u_dut1 (
    .clk(clk), .reset(reset_s), .load(load_s & sel), .addr(addr_s),
    .incr(incr_s & sel), .busy(busy1), .done(done1), .sreg_clk(sclk1),
    .sreg_in(sin1), .sreg_en_n(en1), .sreg_counter_n(cnt1)
  );

  // Behavioural CPLD receivers: shift on rise when enabled, +1 on strobe.
  logic [DW-1:0] rx2 = '0;
  logic [DW-1:0] rx1 = '0;
  int rises2 = 0;
  int rises1 = 0;

  always @(posedge sclk2) begin
    rises2 <= rises2 + 1;
    if (!en2) rx2 <= {rx2[DW-2:0], sin2};
    else if (!cnt2) rx2 <= rx2 + 21'd1;
  end

  always @(posedge sclk1) begin
    rises1 <= rises1 + 1;
    if (!en1) rx1 <= {rx1[DW-2:0], sin1};
    else if (!cnt1) rx1 <= rx1 + 21'd1;
  end

  logic busy_m, done_m, sclk_m, en_m, cnt_m;
  logic [DW-1:0] rx_m;
  int rises_m;
  assign busy_m  = sel ? busy1 : busy2;
  assign done_m  = sel ? done1 : done2;
  assign sclk_m  = sel ? sclk1 : sclk2;
  assign en_m    = sel ? en1   : en2;
  assign cnt_m   = sel ? cnt1  : cnt2;
  assign rx_m    = sel ? rx1   : rx2;
  assign rises_m = sel ? rises1 : rises2;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int cd();
    return sel ? 1 : 2;
  endfunction

  // Monitor: pops the scoreboard on every done pulse, watches pin ordering.
  initial begin : monitor
    exp_t e;
    int busy_cnt = 0;
    int rise_base = 0;
    logic prev_en = 1'b1;
    logic prev_cn = 1'b1;
    logic prev_clk = 1'b0;
    logic prev_sel = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (sel !== prev_sel) rise_base = rises_m;
      if (reset_s) begin
        q.delete();
        busy_cnt = 0;
        rise_base = rises_m;
      end else begin
        if (en_m !== prev_en) check("en_n_change_clk_low", {62'd0, prev_clk, sclk_m}, 64'd0);
        if (cnt_m !== prev_cn) check("counter_n_change_clk_low", {62'd0, prev_clk, sclk_m}, 64'd0);
        if (busy_m) busy_cnt++;
        if (done_m) begin
          if (q.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            check("latency", cyc - e.start, e.lat);
            check("rx_value", rx_m, e.rx);
            check("rise_count", rises_m - rise_base, e.rises);
            check("busy_cycles", busy_cnt, e.lat - 1);
          end
          busy_cnt = 0;
          rise_base = rises_m;
        end
      end
      prev_en = en_m;
      prev_cn = cnt_m;
      prev_clk = sclk_m;
      prev_sel = sel;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_m === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("idle_timeout", n, 0);
  endtask

  // Issue one request at a negedge and record the expected outcome.
  task automatic issue(input logic do_ld, input logic do_in, input logic [DW-1:0] a);
    wait_idle();
    load_s = do_ld;
    incr_s = do_in;
    addr_s = a;
    if (do_ld) begin
      rx_exp = a;
      q.push_back('{2 * cd() * DW + cd() + 1, a, DW, cyc});
    end else if (do_in) begin
      rx_exp = rx_exp + 21'd1;
      q.push_back('{3 * cd() + 1, rx_exp, 1, cyc});
    end
    @(negedge clk);
    load_s = 1'b0;
    incr_s = 1'b0;
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: issue(1'b0, 1'b1, '0);
        1: issue(1'b1, 1'b1, DW'($urandom));
        default: issue(1'b1, 1'b0, DW'($urandom));
      endcase
    end
  endtask

  task automatic check_idle(input string nm, input logic b, input logic d, input logic c,
                            input logic s, input logic e, input logic n);
    check({nm, "_busy"}, b, 1'b0);
    check({nm, "_done"}, d, 1'b0);
    check({nm, "_sreg_clk"}, c, 1'b0);
    check({nm, "_sreg_in"}, s, 1'b0);
    check({nm, "_sreg_en_n"}, e, 1'b1);
    check({nm, "_sreg_counter_n"}, n, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : driver
    logic [DW-1:0] a;
    repeat (3) @(negedge clk);
    reset_s = 1'b0;
    @(negedge clk);
    check_idle("reset_div2", busy2, done2, sclk2, sin2, en2, cnt2);
    check_idle("reset_div1", busy1, done1, sclk1, sin1, en1, cnt1);

    // CLKDIV=2 directed cases
    issue(1'b1, 1'b0, 21'h1A5F3C);
    wait_idle();
    check("rx_1A5F3C", rx_m, 21'h1A5F3C);

    issue(1'b1, 1'b0, 21'h1FFFFF);
    issue(1'b0, 1'b1, '0);
    wait_idle();
    check("rx_incr_wrap", rx_m, 21'h000000);

    issue(1'b1, 1'b1, 21'h000055);
    wait_idle();
    repeat (10) @(negedge clk);
    check("rx_load_wins", rx_m, 21'h000055);

    a = DW'($urandom);
    issue(1'b1, 1'b0, a);
    repeat (10) @(negedge clk);
    load_s = 1'b1;
    incr_s = 1'b1;
    addr_s = ~a;
    @(negedge clk);
    load_s = 1'b0;
    incr_s = 1'b0;
    repeat (20) begin
      @(negedge clk);
      addr_s = DW'($urandom);
    end
    wait_idle();
    repeat (10) @(negedge clk);
    check("rx_ignored_while_busy", rx_m, a);

    issue(1'b1, 1'b0, DW'($urandom));
    repeat (28) @(negedge clk);
    reset_s = 1'b1;
    @(negedge clk);
    reset_s = 1'b0;
    check("midreset_sreg_en_n", en_m, 1'b1);
    check("midreset_sreg_clk", sclk_m, 1'b0);
    check("midreset_busy", busy_m, 1'b0);
    check("midreset_done", done_m, 1'b0);
    repeat (5) @(negedge clk);
    issue(1'b1, 1'b0, 21'h0ABCDE);
    wait_idle();
    check("rx_after_reset", rx_m, 21'h0ABCDE);

    rand_ops(8);
    wait_idle();

    // CLKDIV=1 instance
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, DW'($urandom));
    issue(1'b0, 1'b1, '0);
    rand_ops(8);
    wait_idle();

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
